// File: rtl/bmp_stream_writer.sv
// bmp_stream_writer: streams a framebuffer out as a complete BMP file over a valid/ready byte interface
module bmp_stream_writer #(
    parameter int WIDTH     = 800,
    parameter int HEIGHT    = 600,
    parameter int BPP       = 8,
    parameter int ADDR_W    = 20,
    parameter int BOTTOM_UP = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              fb_rd_en,
    output logic [ADDR_W-1:0] fb_addr,
    input  logic [BPP-1:0]    fb_rdata,
    output logic [7:0]        m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast
);
    localparam logic        P8     = (BPP == 8);
    localparam logic [31:0] OFFSET = 32'(54 + (BPP == 8 ? 1024 : 0));
    localparam logic [31:0] ROWB   = 32'(WIDTH * BPP / 8);
    localparam logic [31:0] STRIDE = (ROWB + 32'd3) & ~32'd3;
    localparam logic [31:0] PADN   = STRIDE - ROWB;
    localparam logic [31:0] IMGSZ  = STRIDE * 32'(HEIGHT);
    localparam logic [31:0] FSIZE  = OFFSET + IMGSZ;
    localparam logic [31:0] NPIX   = 32'(WIDTH * HEIGHT);
    localparam logic [31:0] HFIELD = BOTTOM_UP != 0 ? 32'(HEIGHT) : -32'(HEIGHT);
    localparam logic [31:0] COLORS = BPP == 8 ? 32'd256 : 32'd0;
    localparam logic [ADDR_W-1:0] A_FIRST = BOTTOM_UP != 0 ? ADDR_W'((HEIGHT - 1) * WIDTH) : '0;
    localparam logic [ADDR_W-1:0] A_BACK  = ADDR_W'(2 * WIDTH - 1);

    typedef enum logic [2:0] {IDLE, HDR, PAL, PIX, PAD, DONE} state_t;

    state_t            state_q, state_d;
    logic [10:0]       idx_q, idx_d;
    logic [31:0]       col_q, col_d;
    logic [1:0]        sub_q, sub_d;
    logic [31:0]       bcnt_q, bcnt_d;
    logic              ov_q, ov_d, ol_q, ol_d;
    logic [7:0]        od_q, od_d;
    logic [BPP-1:0]    f0_q, f0_d, f1_q, f1_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              pend_q;
    logic [31:0]       rdl_q, rdl_d;
    logic [11:0]       rx_q, rx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BPP-1:0]    head;
    logic [23:0]       h24;
    logic [7:0]        pix_byte;
    logic              avail, load, rd, last, emit, pop, wrap;

    // Header bytes: after "BM" every field is a little-endian 32-bit word starting at byte 2
    function automatic logic [7:0] hdr_byte(input logic [5:0] i);
        logic [5:0]  j;
        logic [31:0] w;
        j = i - 6'd2;
        case (j[5:2])
            4'd0:       w = FSIZE;
            4'd2:       w = OFFSET;
            4'd3:       w = 32'd40;
            4'd4:       w = 32'(WIDTH);
            4'd5:       w = HFIELD;
            4'd6:       w = {16'(BPP), 16'd1};
            4'd8:       w = IMGSZ;
            4'd9, 4'd10: w = 32'd2835;
            4'd11:      w = COLORS;
            default:    w = 32'd0;
        endcase
        return i == 6'd0 ? 8'h42 : i == 6'd1 ? 8'h4D : 8'(w >> {j[1:0], 3'b000});
    endfunction

    assign busy     = state_q != IDLE && state_q != DONE;
    assign done     = state_q == DONE;
    assign m_tdata  = od_q;
    assign m_tvalid = ov_q;
    assign m_tlast  = ol_q;
    assign fb_addr  = addr_q;
    assign fb_rd_en = rd;
    assign head     = cnt_q != 2'd0 ? f0_q : fb_rdata;
    assign avail    = cnt_q != 2'd0 || pend_q;
    assign h24      = 24'(head);
    assign pix_byte = sub_q == 2'd0 ? h24[7:0] : sub_q == 2'd1 ? h24[15:8] : h24[23:16];
    assign load     = (!ov_q || m_tready) && !ol_q;
    assign rd       = busy && rdl_q != 32'd0 && ({1'b0, cnt_q} + {2'b00, pend_q}) < 3'd2;
    assign last     = bcnt_q == FSIZE - 32'd1;
    assign wrap     = rx_q == 12'(WIDTH - 1);

    // Byte sequencer: picks the next byte whenever the output register is free or being drained
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        col_d   = col_q;
        sub_d   = sub_q;
        bcnt_d  = bcnt_q;
        ov_d    = ov_q && !m_tready;
        od_d    = od_q;
        ol_d    = ol_q;
        emit    = 1'b0;
        pop     = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = HDR;
                idx_d   = 11'd1;
                col_d   = 32'd0;
                sub_d   = 2'd0;
                bcnt_d  = 32'd1;
                ov_d    = 1'b1;
                od_d    = 8'h42;
                ol_d    = 1'b0;
            end
            HDR: if (load) begin
                emit    = 1'b1;
                od_d    = hdr_byte(idx_q[5:0]);
                idx_d   = idx_q == 11'd53 ? 11'd0 : idx_q + 11'd1;
                state_d = idx_q != 11'd53 ? HDR : P8 ? PAL : PIX;
            end
            PAL: if (load) begin
                emit    = 1'b1;
                od_d    = idx_q[1:0] == 2'd3 ? 8'h00 : idx_q[9:2];
                idx_d   = idx_q == 11'd1023 ? 11'd0 : idx_q + 11'd1;
                state_d = idx_q == 11'd1023 ? PIX : PAL;
            end
            PIX: if (load && avail) begin
                emit    = 1'b1;
                od_d    = pix_byte;
                pop     = P8 || sub_q == 2'd2;
                sub_d   = pop ? 2'd0 : sub_q + 2'd1;
                col_d   = col_q == ROWB - 32'd1 ? 32'd0 : col_q + 32'd1;
                state_d = col_q == ROWB - 32'd1 && PADN != 32'd0 ? PAD : PIX;
            end
            PAD: if (load) begin
                emit    = 1'b1;
                od_d    = 8'h00;
                idx_d   = idx_q == 11'(PADN - 1) ? 11'd0 : idx_q + 11'd1;
                state_d = idx_q == 11'(PADN - 1) ? PIX : PAD;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (emit) begin
            ov_d   = 1'b1;
            ol_d   = last;
            bcnt_d = bcnt_q + 32'd1;
        end
        if (ov_q && ol_q && m_tready) begin
            state_d = DONE;
            ol_d    = 1'b0;
        end
    end

    // Two-entry pixel FIFO; arriving read data bypasses straight to the consumer when empty
    always_comb begin
        cnt_d = cnt_q + {1'b0, pend_q} - {1'b0, pop};
        f0_d  = pop ? (cnt_q == 2'd2 ? f1_q : fb_rdata) : (pend_q && cnt_q == 2'd0) ? fb_rdata : f0_q;
        f1_d  = (!pop && pend_q && cnt_q == 2'd1) ? fb_rdata : f1_q;
    end

    // Read address walker; holds the last address so nothing past the image is ever presented
    always_comb begin
        rdl_d  = rdl_q;
        rx_d   = rx_q;
        addr_d = addr_q;
        if (state_q == IDLE && start) begin
            rdl_d  = NPIX;
            rx_d   = 12'd0;
            addr_d = A_FIRST;
        end else if (rd) begin
            rdl_d = rdl_q - 32'd1;
            if (rdl_q != 32'd1) begin
                rx_d   = wrap ? 12'd0 : rx_q + 12'd1;
                addr_d = wrap && BOTTOM_UP != 0 ? addr_q - A_BACK : addr_q + ADDR_W'(1);
            end
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            col_q   <= '0;
            sub_q   <= '0;
            bcnt_q  <= '0;
            ov_q    <= 1'b0;
            od_q    <= '0;
            ol_q    <= 1'b0;
            f0_q    <= '0;
            f1_q    <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            rdl_q   <= '0;
            rx_q    <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            col_q   <= col_d;
            sub_q   <= sub_d;
            bcnt_q  <= bcnt_d;
            ov_q    <= ov_d;
            od_q    <= od_d;
            ol_q    <= ol_d;
            f0_q    <= f0_d;
            f1_q    <= f1_d;
            cnt_q   <= cnt_d;
            pend_q  <= rd;
            rdl_q   <= rdl_d;
            rx_q    <= rx_d;
            addr_q  <= addr_d;
        end
    end
endmodule

// File: tb/tb_bmp_stream_writer.sv
// tb_bmp_stream_writer: scoreboard bench over three writer configurations
module tb_bmp_stream_writer;
    logic       clk = 1'b0;
    logic       rst, tready;
    logic [2:0] st, busy, done, rde, tv, tl;
    logic [7:0] td [3];
    logic [19:0] fa [3];
    logic [7:0]  rd0, rd2;
    logic [23:0] rd1;
    logic [7:0]  q[$], cap[$], ref0[$];
    int          checks = 0, errors = 0, exp_len;
    int          rc [3][8];
    int          bad [3];

    always #5 clk = ~clk;

    bmp_stream_writer #(.WIDTH(3), .HEIGHT(2), .BPP(8), .ADDR_W(20), .BOTTOM_UP(1)) u0 (
        .clk(clk), .rst(rst), .start(st[0]), .busy(busy[0]), .done(done[0]), .fb_rd_en(rde[0]),
        .fb_addr(fa[0]), .fb_rdata(rd0), .m_tdata(td[0]), .m_tvalid(tv[0]), .m_tready(tready), .m_tlast(tl[0]));
    bmp_stream_writer #(.WIDTH(3), .HEIGHT(2), .BPP(24), .ADDR_W(20), .BOTTOM_UP(0)) u1 (
        .clk(clk), .rst(rst), .start(st[1]), .busy(busy[1]), .done(done[1]), .fb_rd_en(rde[1]),
        .fb_addr(fa[1]), .fb_rdata(rd1), .m_tdata(td[1]), .m_tvalid(tv[1]), .m_tready(tready), .m_tlast(tl[1]));
    bmp_stream_writer #(.WIDTH(4), .HEIGHT(1), .BPP(8), .ADDR_W(20), .BOTTOM_UP(1)) u2 (
        .clk(clk), .rst(rst), .start(st[2]), .busy(busy[2]), .done(done[2]), .fb_rd_en(rde[2]),
        .fb_addr(fa[2]), .fb_rdata(rd2), .m_tdata(td[2]), .m_tvalid(tv[2]), .m_tready(tready), .m_tlast(tl[2]));

    function automatic logic [23:0] fbval(input int k, input int a);
        return k == 1 ? 24'hC0B0A0 + 24'(a) : k == 0 ? 24'(8'h10 + 8'(a)) : 24'(8'h50 + 8'(a));
    endfunction

    function automatic int np(input int k);
        return k == 2 ? 4 : 6;
    endfunction

    // Framebuffer models with one-cycle read latency, plus per-address read accounting
    always @(posedge clk) begin
        if (rde[0]) rd0 <= 8'(fbval(0, int'(fa[0])));
        if (rde[1]) rd1 <= fbval(1, int'(fa[1]));
        if (rde[2]) rd2 <= 8'(fbval(2, int'(fa[2])));
        for (int i = 0; i < 3; i++)
            if (rde[i]) begin
                if (int'(fa[i]) < np(i)) rc[i][fa[i][2:0]] += 1;
                else bad[i] += 1;
            end
    end

    task automatic push32(input logic [31:0] v);
        for (int b = 0; b < 4; b++) q.push_back(8'(v >> (8 * b)));
    endtask

    task automatic build_exp(input int k);
        int w, h, bp, bu, rowb, stride, off, y;
        logic [23:0] v;
        w = k == 2 ? 4 : 3;
        h = k == 2 ? 1 : 2;
        bp = k == 1 ? 24 : 8;
        bu = k != 1 ? 1 : 0;
        rowb = w * bp / 8;
        stride = (rowb + 3) & ~3;
        off = 54 + (bp == 8 ? 1024 : 0);
        q.delete();
        q.push_back(8'h42);
        q.push_back(8'h4D);
        push32(32'(off + stride * h));
        push32(0);
        push32(32'(off));
        push32(40);
        push32(32'(w));
        push32(bu != 0 ? 32'(h) : -32'(h));
        q.push_back(8'd1); q.push_back(8'd0);
        q.push_back(8'(bp)); q.push_back(8'd0);
        push32(0);
        push32(32'(stride * h));
        push32(2835);
        push32(2835);
        push32(bp == 8 ? 256 : 0);
        push32(0);
        if (bp == 8)
            for (int i = 0; i < 256; i++) begin
                q.push_back(8'(i)); q.push_back(8'(i)); q.push_back(8'(i)); q.push_back(8'h00);
            end
        for (int r = 0; r < h; r++) begin
            y = bu != 0 ? h - 1 - r : r;
            for (int x = 0; x < w; x++) begin
                v = fbval(k, y * w + x);
                q.push_back(v[7:0]);
                if (bp == 24) begin q.push_back(v[15:8]); q.push_back(v[23:16]); end
            end
            for (int p = rowb; p < stride; p++) q.push_back(8'h00);
        end
        exp_len = q.size();
    endtask

    // Runs one file on DUT k, scoreboarding every accepted byte; ends on a negedge in IDLE
    task automatic run_file(input int k, input bit rnd, input int abort_at, input bit hold);
        int cyc = 0, n = 0;
        bit stall = 0;
        logic [7:0] ptd = 0, e;
        logic ptl = 0;
        build_exp(k);
        cap.delete();
        for (int p = 0; p < 8; p++) rc[k][p] = 0;
        bad[k] = 0;
        tready = 1'b1;
        if (!st[k]) st[k] = 1'b1;
        @(negedge clk);
        if (!hold) st[k] = 1'b0;
        checks++;
        if (busy[k] !== 1'b1 || tv[k] !== 1'b1 || td[k] !== 8'h42) begin
            errors++;
            $display("FAIL start_latency: busy=%b valid=%b data=%h, want 1 1 42", busy[k], tv[k], td[k]);
        end
        while (q.size() != 0 && cyc < 20000) begin
            if (stall) begin
                checks++;
                if (tv[k] !== 1'b1 || td[k] !== ptd || tl[k] !== ptl) begin
                    errors++;
                    $display("FAIL stall_hold: valid=%b data=%h last=%b, want 1 %h %b", tv[k], td[k], tl[k], ptd, ptl);
                end
            end
            tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (abort_at >= 0 && n == abort_at) begin
                tready = 1'b0;
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                checks++;
                if ({busy[k], done[k], rde[k], tv[k], tl[k]} !== 5'b0 || td[k] !== 8'h00 || fa[k] !== 20'd0) begin
                    errors++;
                    $display("FAIL abort_reset: busy=%b done=%b rd=%b valid=%b last=%b data=%h addr=%h, want all 0",
                             busy[k], done[k], rde[k], tv[k], tl[k], td[k], fa[k]);
                end
                for (int i = 0; i < 6; i++) begin
                    @(negedge clk);
                    checks++;
                    if (done[k] !== 1'b0 || busy[k] !== 1'b0) begin
                        errors++;
                        $display("FAIL abort_no_done: done=%b busy=%b, want 0 0", done[k], busy[k]);
                    end
                end
                return;
            end
            if (tv[k] && tready) begin
                e = q.pop_front();
                cap.push_back(td[k]);
                checks++;
                if (td[k] !== e || tl[k] !== (q.size() == 0)) begin
                    errors++;
                    $display("FAIL byte_%0d: data=%h last=%b, want %h %b", n, td[k], tl[k], e, q.size() == 0);
                end
                n++;
            end
            stall = tv[k] && !tready;
            ptd = td[k];
            ptl = tl[k];
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL timeout: %0d bytes still expected after %0d cycles", q.size(), cyc);
        end
        if (!rnd) begin
            checks++;
            if (cyc != exp_len) begin
                errors++;
                $display("FAIL throughput: %0d cycles for file, want %0d", cyc, exp_len);
            end
        end
        checks++;
        if (done[k] !== 1'b1 || busy[k] !== 1'b0 || tv[k] !== 1'b0) begin
            errors++;
            $display("FAIL done_cycle: done=%b busy=%b valid=%b, want 1 0 0", done[k], busy[k], tv[k]);
        end
        @(negedge clk);
        checks++;
        if (done[k] !== 1'b0 || busy[k] !== 1'b0 || tv[k] !== 1'b0) begin
            errors++;
            $display("FAIL idle_cycle: done=%b busy=%b valid=%b, want 0 0 0", done[k], busy[k], tv[k]);
        end
        for (int p = 0; p < np(k); p++) begin
            checks++;
            if (rc[k][p] != 1) begin
                errors++;
                $display("FAIL read_once_%0d: address read %0d times, want 1", p, rc[k][p]);
            end
        end
        checks++;
        if (bad[k] != 0) begin
            errors++;
            $display("FAIL read_range: %0d reads past the image, want 0", bad[k]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        st = 3'b000;
        tready = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({busy[i], done[i], rde[i], tv[i], tl[i]} !== 5'b0 || td[i] !== 8'h00 || fa[i] !== 20'd0) begin
                errors++;
                $display("FAIL reset_%0d: busy=%b done=%b rd=%b valid=%b last=%b data=%h addr=%h, want all 0",
                         i, busy[i], done[i], rde[i], tv[i], tl[i], td[i], fa[i]);
            end
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_bpp8();
        logic [7:0] e [16];
        e = '{8'h3E, 8'h04, 8'h00, 8'h00, 8'h36, 8'h04, 8'h00, 8'h00,
              8'h13, 8'h14, 8'h15, 8'h00, 8'h10, 8'h11, 8'h12, 8'h00};
        run_file(0, 0, -1, 0);
        ref0 = cap;
        checks++;
        if (cap.size() != 1086) begin
            errors++;
            $display("FAIL bpp8_len: %0d bytes, want 1086", cap.size());
        end
        for (int i = 0; i < 16; i++) begin
            int a;
            a = i < 4 ? 2 + i : i < 8 ? 6 + i : 1070 + i;
            checks++;
            if (cap[a] !== e[i]) begin
                errors++;
                $display("FAIL bpp8_byte_%0d: got %h, want %h", a, cap[a], e[i]);
            end
        end
    endtask

    task automatic test_bpp24();
        logic [7:0] e [16];
        e = '{8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'hA0, 8'hB0, 8'hC0, 8'hA1,
              8'hB0, 8'hC0, 8'hA2, 8'hB0, 8'hC0, 8'h00, 8'h00, 8'h00};
        run_file(1, 0, -1, 0);
        checks++;
        if (cap.size() != 78) begin
            errors++;
            $display("FAIL bpp24_len: %0d bytes, want 78", cap.size());
        end
        for (int i = 0; i < 16; i++) begin
            int a;
            a = i < 4 ? 22 + i : 50 + i;
            checks++;
            if (cap[a] !== e[i]) begin
                errors++;
                $display("FAIL bpp24_byte_%0d: got %h, want %h", a, cap[a], e[i]);
            end
        end
    endtask

    task automatic test_nopad();
        logic [7:0] e [4];
        e = '{8'h50, 8'h51, 8'h52, 8'h53};
        run_file(2, 0, -1, 0);
        checks++;
        if (cap.size() != 1082) begin
            errors++;
            $display("FAIL nopad_len: %0d bytes, want 1082", cap.size());
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cap[1078 + i] !== e[i]) begin
                errors++;
                $display("FAIL nopad_byte_%0d: got %h, want %h", 1078 + i, cap[1078 + i], e[i]);
            end
        end
    endtask

    task automatic test_random_ready();
        int diff = 0;
        run_file(0, 1, -1, 0);
        for (int i = 0; i < ref0.size(); i++) if (i >= cap.size() || cap[i] !== ref0[i]) diff++;
        checks++;
        if (diff != 0 || cap.size() != ref0.size()) begin
            errors++;
            $display("FAIL random_ready_stream: %0d differing bytes, %0d bytes, want 0 and %0d", diff, cap.size(), ref0.size());
        end
    endtask

    task automatic test_abort();
        int diff = 0;
        run_file(0, 0, 600, 0);
        run_file(0, 0, -1, 0);
        for (int i = 0; i < ref0.size(); i++) if (i >= cap.size() || cap[i] !== ref0[i]) diff++;
        checks++;
        if (diff != 0 || cap.size() != 1086) begin
            errors++;
            $display("FAIL abort_restart: %0d differing bytes, %0d bytes, want 0 and 1086", diff, cap.size());
        end
    endtask

    task automatic test_back_to_back();
        run_file(0, 0, -1, 1);
        run_file(0, 0, -1, 1);
        st[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (busy[0] !== 1'b0 || tv[0] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_stop: busy=%b valid=%b, want 0 0", busy[0], tv[0]);
        end
    endtask

    initial begin
        test_reset();
        test_bpp8();
        test_bpp24();
        test_nopad();
        test_random_ready();
        test_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
